// File: rtl/jtag_types_pkg.sv
// Shared JTAG types: IR length, instruction type, opcode constants and an opcode validity helper.
package jtag_types_pkg;

    localparam int IR_WIDTH = 5;

    typedef logic [IR_WIDTH-1:0] instruction_t;

    localparam instruction_t EXTEST         = 5'b00000;
    localparam instruction_t IDCODE         = 5'b00001;
    localparam instruction_t SAMPLE_PRELOAD = 5'b00010;
    localparam instruction_t CLAMP_HOLD     = 5'b00101;
    localparam instruction_t CLAMP_RELEASE  = 5'b00110;
    localparam instruction_t TMP_STATUS     = 5'b00111;
    localparam instruction_t AHB            = 5'b01000;
    localparam instruction_t AHB_FIFO_READ  = 5'b01001;
    localparam instruction_t BYPASS         = 5'b11111;

    function automatic logic is_valid_opcode(input instruction_t op);
        logic valid;
        valid = 1'b0;
        case (op)
            EXTEST, IDCODE, SAMPLE_PRELOAD, CLAMP_HOLD, CLAMP_RELEASE,
            TMP_STATUS, AHB, AHB_FIFO_READ, BYPASS: valid = 1'b1;
            default:                                valid = 1'b0;
        endcase
        return valid;
    endfunction

endpackage

// File: rtl/instruction_register.sv
// JTAG instruction register: capture/shift/update path between TAP controller and decoder.
// Define IR_INVALID_TO_BYPASS_EN to load undefined opcodes as BYPASS on Update-IR.
module instruction_register #(
    parameter int IR_WIDTH = jtag_types_pkg::IR_WIDTH
) (
    input  logic                TCK,
    input  logic                TRST_n,
    input  logic                tlr,
    input  logic                capture_ir,
    input  logic                shift_ir,
    input  logic                update_ir,
    input  logic                tdi,
    input  logic [IR_WIDTH-3:0] capture_status,
    output logic                ir_tdo,
    output logic [IR_WIDTH-1:0] parallel_out,
    output logic                ir_length_err
);
    import jtag_types_pkg::*;

    if (IR_WIDTH != $bits(instruction_t)) begin : g_width_check
        $error("instruction_register: IR_WIDTH must equal $bits(instruction_t)");
    end

    localparam int CNT_W = $clog2(IR_WIDTH + 2);
    localparam logic [CNT_W-1:0]    CNT_SAT     = CNT_W'(IR_WIDTH + 1);
    localparam logic [CNT_W-1:0]    CNT_EXACT   = CNT_W'(IR_WIDTH);
    localparam logic [IR_WIDTH-1:0] SHIFT_RESET = {{(IR_WIDTH-2){1'b0}}, 2'b01};

    logic [IR_WIDTH-1:0] shift_reg_q, shift_reg_d;
    logic [IR_WIDTH-1:0] instr_q, instr_d;
    logic [CNT_W-1:0]    shift_cnt_q, shift_cnt_d;
    logic                length_err_q, length_err_d;
    logic [IR_WIDTH-1:0] update_val;

`ifdef IR_INVALID_TO_BYPASS_EN
    assign update_val = is_valid_opcode(shift_reg_q) ? shift_reg_q : BYPASS;
`else
    assign update_val = shift_reg_q;
`endif

    always_comb begin
        shift_reg_d  = shift_reg_q;
        instr_d      = instr_q;
        shift_cnt_d  = shift_cnt_q;
        length_err_d = length_err_q;
        if (tlr) begin
            shift_reg_d  = SHIFT_RESET;
            instr_d      = IDCODE;
            shift_cnt_d  = '0;
            length_err_d = 1'b0;
        end else if (capture_ir) begin
            shift_reg_d  = {capture_status, 2'b01};
            shift_cnt_d  = '0;
            length_err_d = 1'b0;
        end else if (shift_ir) begin
            shift_reg_d = {tdi, shift_reg_q[IR_WIDTH-1:1]};
            // Saturate so over-long scans can never wrap back to a legal count.
            if (shift_cnt_q != CNT_SAT) begin
                shift_cnt_d = shift_cnt_q + 1'b1;
            end
        end else if (update_ir) begin
            instr_d      = update_val;
            length_err_d = (shift_cnt_q != CNT_EXACT);
        end
    end

    always_ff @(posedge TCK or negedge TRST_n) begin
        if (!TRST_n) begin
            shift_reg_q  <= SHIFT_RESET;
            instr_q      <= IDCODE;
            shift_cnt_q  <= '0;
            length_err_q <= 1'b0;
        end else begin
            shift_reg_q  <= shift_reg_d;
            instr_q      <= instr_d;
            shift_cnt_q  <= shift_cnt_d;
            length_err_q <= length_err_d;
        end
    end

    assign ir_tdo        = shift_reg_q[0];
    assign parallel_out  = instr_q;
    assign ir_length_err = length_err_q;

endmodule

// File: tb/tb_instruction_register.sv
// Self-checking bench for instruction_register: directed scan scenarios plus randomized scans vs a bit-stream model.
module tb_instruction_register;

    logic       TCK = 1'b0;
    logic       TRST_n = 1'b0;
    logic       tlr = 1'b0;
    logic       capture_ir = 1'b0;
    logic       shift_ir = 1'b0;
    logic       update_ir = 1'b0;
    logic       tdi = 1'b0;
    logic [2:0] capture_status = 3'b000;
    logic       ir_tdo;
    logic [4:0] parallel_out;
    logic       ir_length_err;

    int errors = 0;
    int checks = 0;

    // Model: the scan is a bit stream -- captured word followed by tdi bits, read from position m_n.
    logic [4:0] m_cap = 5'b00001;
    bit         m_in[$];
    int         m_n = 0;
    logic [4:0] m_par = 5'b00001;
    logic       m_err = 1'b0;

    instruction_register dut (
        .TCK(TCK), .TRST_n(TRST_n), .tlr(tlr), .capture_ir(capture_ir),
        .shift_ir(shift_ir), .update_ir(update_ir), .tdi(tdi),
        .capture_status(capture_status), .ir_tdo(ir_tdo),
        .parallel_out(parallel_out), .ir_length_err(ir_length_err)
    );

    always #5 TCK = ~TCK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [4:0] exp_reg();
        logic [4:0] r;
        for (int i = 0; i < 5; i++) begin
            r[i] = (m_n + i < 5) ? m_cap[m_n + i] : m_in[m_n + i - 5];
        end
        return r;
    endfunction

    function automatic logic known_op(input logic [4:0] v);
        logic [4:0] ops [9] = '{5'd0, 5'd1, 5'd2, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd31};
        foreach (ops[i]) if (ops[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_tdo();
        logic [4:0] r;
        r = exp_reg();
        return r[0];
    endfunction

    task automatic tick();
        @(posedge TCK);
        #1;
    endtask

    task automatic model_reset();
        m_cap = 5'b00001;
        m_in.delete();
        m_n = 0;
        m_par = 5'b00001;
        m_err = 1'b0;
    endtask

    task automatic cap(input logic [2:0] st);
        capture_status = st;
        capture_ir = 1'b1;
        tick();
        capture_ir = 1'b0;
        m_cap = {st, 2'b01};
        m_in.delete();
        m_n = 0;
        m_err = 1'b0;
        chk("cap_par_hold", parallel_out, m_par);
        chk("cap_err", ir_length_err, m_err);
        chk("cap_tdo", ir_tdo, exp_tdo());
    endtask

    task automatic shf(input bit b);
        chk("tdo", ir_tdo, exp_tdo());
        tdi = b;
        shift_ir = 1'b1;
        tick();
        shift_ir = 1'b0;
        m_in.push_back(b);
        m_n++;
        chk("shift_par_hold", parallel_out, m_par);
    endtask

    task automatic shf_word(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) shf(v[i]);
    endtask

    task automatic upd();
        logic [4:0] v;
        update_ir = 1'b1;
        tick();
        update_ir = 1'b0;
        v = exp_reg();
`ifdef IR_INVALID_TO_BYPASS_EN
        if (!known_op(v)) v = 5'b11111;
`endif
        m_par = v;
        m_err = (m_n != 5);
        chk("upd_par", parallel_out, m_par);
        chk("upd_err", ir_length_err, m_err);
    endtask

    initial begin
        #12;
        chk("rst_par", parallel_out, 5'b00001);
        chk("rst_tdo", ir_tdo, 1'b1);
        chk("rst_err", ir_length_err, 1'b0);
        TRST_n = 1'b1;
        tick();

        // Captured status visible LSB first on tdo.
        cap(3'b101);
        chk("seq0", ir_tdo, 1'b1); shf(1'b0);
        chk("seq1", ir_tdo, 1'b0); shf(1'b0);
        chk("seq2", ir_tdo, 1'b1); shf(1'b0);
        chk("seq3", ir_tdo, 1'b0); shf(1'b0);
        chk("seq4", ir_tdo, 1'b1); shf(1'b0);

        cap(3'b000);
        shf_word(16'b01000, 5);
        upd();
        chk("ahb_par", parallel_out, 5'b01000);
        chk("ahb_err", ir_length_err, 1'b0);

        cap(3'b011);
        shf_word(16'b001011, 6);
        upd();
        chk("long_par", parallel_out, 5'b00101);
        chk("long_err", ir_length_err, 1'b1);
        cap(3'b000);
        chk("err_clear", ir_length_err, 1'b0);

        shf_word(16'b10101, 5);
        upd();
`ifdef IR_INVALID_TO_BYPASS_EN
        chk("invalid_par", parallel_out, 5'b11111);
`else
        chk("invalid_par", parallel_out, 5'b10101);
`endif

        cap(3'b000);
        shf_word(16'b01001, 5);
        upd();
        chk("fifo_par", parallel_out, 5'b01001);
        tlr = 1'b1;
        tick();
        tlr = 1'b0;
        model_reset();
        chk("tlr_par", parallel_out, 5'b00001);
        chk("tlr_tdo", ir_tdo, 1'b1);

        // Capture beats a simultaneous update: parallel_out holds, error clears.
        cap(3'b000);
        shf_word(16'b00110, 3);
        upd();
        chk("short_err", ir_length_err, 1'b1);
        capture_status = 3'b110;
        capture_ir = 1'b1;
        update_ir = 1'b1;
        tick();
        capture_ir = 1'b0;
        update_ir = 1'b0;
        m_cap = 5'b11001; m_in.delete(); m_n = 0; m_err = 1'b0;
        chk("cu_par", parallel_out, m_par);
        chk("cu_err", ir_length_err, 1'b0);
        chk("cu_tdo", ir_tdo, 1'b1);

        // Async reset mid-shift, between clock edges.
        shf_word(16'b01000, 5);
        upd();
        cap(3'b010);
        shf_word(16'b10, 2);
        #2;
        TRST_n = 1'b0;
        #1;
        model_reset();
        chk("arst_par", parallel_out, 5'b00001);
        chk("arst_tdo", ir_tdo, 1'b1);
        chk("arst_err", ir_length_err, 1'b0);
        #1;
        TRST_n = 1'b1;
        tick();

        for (int it = 0; it < 40; it++) begin
            int n;
            cap(3'($urandom_range(0, 7)));
            n = (it % 3 == 0) ? 5 : $urandom_range(0, 14);
            for (int k = 0; k < n; k++) begin
                shf(1'($urandom_range(0, 1)));
                if ($urandom_range(0, 4) == 0) begin
                    tick();
                    chk("idle_tdo", ir_tdo, exp_tdo());
                    chk("idle_par", parallel_out, m_par);
                end
            end
            upd();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
